// File: rtl/protocol_pkg.sv
// Byte-stream command protocol for the oscillator voice bank: register ids,
// payload lengths, framing constants and the shared voice/envelope types.
package protocol_pkg;

    localparam int ENVELOPE_LEN     = 4;
    localparam int FREQ_FIXED_POINT = 16;

    typedef enum logic [1:0] {
        SIN      = 2'd0,
        SQUARE   = 2'd1,
        TRIANGLE = 2'd2,
        SAW      = 2'd3
    } wave_shape;

    localparam logic [7:0] NUM_SHAPES = 8'd4;

    typedef struct packed {
        logic [31:0] gain;
        logic [31:0] duration;
    } envelope_t;

    typedef enum logic [7:0] {
        REG_FREQ      = 8'h00,
        REG_AMPLITUDE = 8'h01,
        REG_SHAPE     = 8'h02,
        REG_ENABLE    = 8'h03,
        REG_CMDS      = 8'h04,
        REG_ENVELOPE  = 8'h10
    } reg_id_t;

    localparam logic [7:0] SYNC_BYTE    = 8'hA5;
    localparam logic [7:0] CMD_ENV_BASE = 8'h10;

    localparam logic [3:0] LEN_FREQ     = 4'd4;
    localparam logic [3:0] LEN_SHAPE    = 4'd1;
    localparam logic [3:0] LEN_ENABLE   = 4'd1;
    localparam logic [3:0] LEN_CMDS     = 4'd1;
    localparam logic [3:0] LEN_ENVELOPE = 4'd8;

    // Zero marks an id the decoder does not know.
    function automatic logic [3:0] payload_len(input logic [7:0] id, input logic [3:0] amp_len);
        logic [3:0] len;
        len = 4'd0;
        case (id)
            REG_FREQ:      len = LEN_FREQ;
            REG_AMPLITUDE: len = amp_len;
            REG_SHAPE:     len = LEN_SHAPE;
            REG_ENABLE:    len = LEN_ENABLE;
            REG_CMDS:      len = LEN_CMDS;
            default: begin
                if (id >= CMD_ENV_BASE && id < CMD_ENV_BASE + 8'(ENVELOPE_LEN))
                    len = LEN_ENVELOPE;
            end
        endcase
        return len;
    endfunction

endpackage

// File: rtl/frame_timeout.sv
// Inter-byte gap counter: counts idle cycles inside a frame and flags expiry
// when the gap reaches TIMEOUT_CYCLES.
module frame_timeout #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expire = count && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear || expire)
            cnt_d = '0;
        else if (count)
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/voice_cmd_decoder.sv
// Decodes framed command bytes into per-voice oscillator settings.
// Define VOICE_CMD_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module voice_cmd_decoder
    import protocol_pkg::*;
#(
    parameter int N_CHANNELS     = 8,
    parameter int WIDTH          = 24,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [7:0]                                   rx_data,
    input  logic                                         rx_valid,
    output logic                                         rx_ready,
    output logic [N_CHANNELS-1:0][31:0]                  freq,
    output logic [N_CHANNELS-1:0][WIDTH-1:0]             amplitude,
    output wave_shape [N_CHANNELS-1:0]                   shape,
    output logic [N_CHANNELS-1:0]                        enable,
    output logic [N_CHANNELS-1:0][7:0]                   cmds,
    output envelope_t [N_CHANNELS-1:0][ENVELOPE_LEN-1:0] envelopes,
    output logic                                         err
);

`ifdef VOICE_CMD_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    localparam int         CH_W    = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
    localparam int         ENV_W   = (ENVELOPE_LEN > 1) ? $clog2(ENVELOPE_LEN) : 1;
    localparam logic [3:0] AMP_LEN = 4'((WIDTH + 7) / 8);

    typedef enum logic [2:0] {IDLE, CHAN, REG, PAYLOAD, COMMIT} state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [7:0]        id_q, id_d;
    logic [7:0]        chk_q, chk_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [63:0]       shadow_q, shadow_d;
    logic              err_q, err_d;
    logic              rx_ready_q;
    logic              accept, in_frame, tm_expire, write_ok;
    logic [3:0]        len;
    logic [ENV_W-1:0]  env_idx;

    logic [N_CHANNELS-1:0][31:0]                  freq_q;
    logic [N_CHANNELS-1:0][WIDTH-1:0]             amp_q;
    wave_shape [N_CHANNELS-1:0]                   shape_q;
    logic [N_CHANNELS-1:0]                        enable_q;
    logic [N_CHANNELS-1:0][7:0]                   cmds_q;
    envelope_t [N_CHANNELS-1:0][ENVELOPE_LEN-1:0] env_q;

    assign accept   = rx_valid && rx_ready_q;
    assign in_frame = (state_q == CHAN) || (state_q == REG) || (state_q == PAYLOAD);
    assign write_ok = !(id_q == REG_SHAPE && shadow_q[7:0] >= NUM_SHAPES);
    // Envelope ids start on an aligned base, so the low id bits are the step.
    assign env_idx  = id_q[ENV_W-1:0];

    frame_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (!in_frame || accept),
        .count  (in_frame && !accept),
        .expire (tm_expire)
    );

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        id_d     = id_q;
        chk_d    = chk_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        err_d    = 1'b0;
        len      = payload_len(rx_data, AMP_LEN);

        case (state_q)
            IDLE: begin
                if (accept && rx_data == SYNC_BYTE)
                    state_d = CHAN;
            end
            CHAN: begin
                if (accept) begin
                    if ({24'd0, rx_data} < 32'(N_CHANNELS)) begin
                        ch_d    = rx_data[CH_W-1:0];
                        chk_d   = rx_data;
                        state_d = REG;
                    end else begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end else if (tm_expire) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            REG: begin
                if (accept) begin
                    if (len != 4'd0) begin
                        id_d    = rx_data;
                        chk_d   = chk_q ^ rx_data;
                        cnt_d   = len + 4'(CHK_EN);
                        state_d = PAYLOAD;
                    end else begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end else if (tm_expire) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            PAYLOAD: begin
                if (accept) begin
                    if (CHK_EN && cnt_q == 4'd1) begin
                        state_d = (rx_data == chk_q) ? COMMIT : IDLE;
                        err_d   = (rx_data != chk_q);
                    end else begin
                        shadow_d = {shadow_q[55:0], rx_data};
                        chk_d    = chk_q ^ rx_data;
                        cnt_d    = cnt_q - 4'd1;
                        if (!CHK_EN && cnt_q == 4'd1)
                            state_d = COMMIT;
                    end
                end else if (tm_expire) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            COMMIT: begin
                state_d = IDLE;
                err_d   = !write_ok;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            rx_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            rx_ready_q <= (state_d != COMMIT);
        end
        ch_q     <= ch_d;
        id_q     <= id_d;
        chk_q    <= chk_d;
        shadow_q <= shadow_d;
    end

    // Voice fields change only on the COMMIT edge, whole field at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            freq_q   <= '0;
            amp_q    <= '0;
            enable_q <= '0;
            cmds_q   <= '0;
            env_q    <= '0;
            for (int i = 0; i < N_CHANNELS; i++)
                shape_q[i] <= SIN;
        end else begin
            cmds_q <= '0;
            if (state_q == COMMIT && write_ok) begin
                case (id_q)
                    REG_FREQ:      freq_q[ch_q]   <= shadow_q[31:0];
                    REG_AMPLITUDE: amp_q[ch_q]    <= shadow_q[WIDTH-1:0];
                    REG_SHAPE:     shape_q[ch_q]  <= wave_shape'(shadow_q[1:0]);
                    REG_ENABLE:    enable_q[ch_q] <= shadow_q[0];
                    REG_CMDS:      cmds_q[ch_q]   <= shadow_q[7:0];
                    default:       env_q[ch_q][env_idx] <= shadow_q;
                endcase
            end
        end
    end

    assign rx_ready  = rx_ready_q;
    assign err       = err_q;
    assign freq      = freq_q;
    assign amplitude = amp_q;
    assign shape     = shape_q;
    assign enable    = enable_q;
    assign cmds      = cmds_q;
    assign envelopes = env_q;

endmodule

// File: tb/tb_voice_cmd_decoder.sv
// Directed bench for voice_cmd_decoder: vector table of complete frames plus
// hand-written sequences for errors, timeout, command pulses and reset.
module tb_voice_cmd_decoder;
    import protocol_pkg::*;

    localparam int N  = 8;
    localparam int W  = 24;
    localparam int TO = 1024;
    localparam int NV = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic rx_valid = 1'b0;
    logic rx_ready;
    logic [N-1:0][31:0] freq;
    logic [N-1:0][W-1:0] amplitude;
    wave_shape [N-1:0] shape;
    logic [N-1:0] enable;
    logic [N-1:0][7:0] cmds;
    envelope_t [N-1:0][ENVELOPE_LEN-1:0] envelopes;
    logic err;
    logic [2*N-1:0] shape_bits;

    assign shape_bits = shape;

    always #5 clk = ~clk;

    voice_cmd_decoder #(
        .N_CHANNELS(N), .WIDTH(W), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .freq(freq), .amplitude(amplitude), .shape(shape),
        .enable(enable), .cmds(cmds), .envelopes(envelopes), .err(err)
    );

    typedef struct packed {
        logic [3:0]  n;
        logic [95:0] bytes;
        logic [2:0]  kind;
        logic [2:0]  ch;
        logic [1:0]  idx;
        logic [63:0] exp;
        logic        exp_err;
    } vec_t;

    vec_t vecs [NV];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int w;
        w = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        while (!rx_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!rx_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL rx_ready_wait: got 0x0, want 0x1");
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_raw(input int n, input logic [95:0] bytes);
        for (int i = 0; i < n; i++)
            send_byte(bytes[95-8*i -: 8]);
    endtask

    task automatic send_frame(input int n, input logic [95:0] bytes);
`ifdef VOICE_CMD_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
        for (int i = 1; i < n; i++)
            x = x ^ bytes[95-8*i -: 8];
        send_raw(n, bytes);
        send_byte(x);
`else
        send_raw(n, bytes);
`endif
    endtask

    function automatic vec_t mk(input int n, input logic [95:0] bytes, input int kind,
                                input int ch, input int idx, input logic [63:0] exp,
                                input logic exp_err);
        vec_t v;
        v.n = 4'(n); v.bytes = bytes; v.kind = 3'(kind); v.ch = 3'(ch);
        v.idx = 2'(idx); v.exp = exp; v.exp_err = exp_err;
        return v;
    endfunction

    function automatic logic [63:0] field(input int kind, input int ch, input int idx);
        case (kind)
            0:       return 64'(freq[ch]);
            1:       return 64'(amplitude[ch]);
            2:       return 64'(shape[ch]);
            3:       return 64'(enable[ch]);
            default: return envelopes[ch][idx];
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = mk(7,  {8'hA5, 8'h02, 8'h00, 32'h00002A00, 40'h0}, 0, 2, 0, 64'h2A00, 1'b0);
        vecs[1] = mk(7,  {8'hA5, 8'h05, 8'h00, 32'h12345678, 40'h0}, 0, 5, 0, 64'h12345678, 1'b0);
        vecs[2] = mk(6,  {8'hA5, 8'h07, 8'h01, 24'hABCDEF, 48'h0},   1, 7, 0, 64'hABCDEF, 1'b0);
        vecs[3] = mk(4,  {8'hA5, 8'h00, 8'h02, 8'h03, 64'h0},        2, 0, 0, 64'h3, 1'b0);
        vecs[4] = mk(4,  {8'hA5, 8'h00, 8'h02, 8'h07, 64'h0},        2, 0, 0, 64'h3, 1'b1);
        vecs[5] = mk(4,  {8'hA5, 8'h04, 8'h03, 8'h01, 64'h0},        3, 4, 0, 64'h1, 1'b0);
        vecs[6] = mk(4,  {8'hA5, 8'h04, 8'h03, 8'hFE, 64'h0},        3, 4, 0, 64'h0, 1'b0);
        vecs[7] = mk(11, {8'hA5, 8'h03, 8'h11, 64'h0000010000000040, 8'h0}, 4, 3, 1, 64'h0000010000000040, 1'b0);
        vecs[8] = mk(11, {8'hA5, 8'h06, 8'h13, 64'hFFFFFFFF00000001, 8'h0}, 4, 6, 3, 64'hFFFFFFFF00000001, 1'b0);
        vecs[9] = mk(7,  {8'hA5, 8'h00, 8'h00, 32'hA5A5A5A5, 40'h0}, 0, 0, 0, 64'hA5A5A5A5, 1'b0);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rx_ready", 64'(rx_ready), 64'h0);
        check("rst_err", 64'(err), 64'h0);
        check("rst_freq", 64'(|freq), 64'h0);
        check("rst_amp", 64'(|amplitude), 64'h0);
        check("rst_shape_sin", 64'(shape_bits), 64'h0);
        check("rst_enable", 64'(enable), 64'h0);
        check("rst_cmds", 64'(cmds), 64'h0);
        check("rst_env", 64'(|envelopes), 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("ready_before_release", 64'(rx_ready), 64'h0);
        tick();
        check("ready_after_release", 64'(rx_ready), 64'h1);

        // Non-sync bytes in IDLE are dropped silently
        send_byte(8'h00);
        check("idle_junk0_err", 64'(err), 64'h0);
        send_byte(8'hFF);
        check("idle_junk1_err", 64'(err), 64'h0);

        for (int i = 0; i < NV; i++) begin
            send_frame(int'(vecs[i].n), vecs[i].bytes);
            check($sformatf("v%0d_ready_commit", i), 64'(rx_ready), 64'h0);
            tick();
            check($sformatf("v%0d_field", i),
                  field(int'(vecs[i].kind), int'(vecs[i].ch), int'(vecs[i].idx)), vecs[i].exp);
            check($sformatf("v%0d_err", i), 64'(err), 64'(vecs[i].exp_err));
            check($sformatf("v%0d_ready_back", i), 64'(rx_ready), 64'h1);
        end

        // Command pulse lasts exactly one cycle on the addressed channel
        send_frame(4, {8'hA5, 8'h01, 8'h04, 8'h01, 64'h0});
        check("cmds_before", 64'(cmds), 64'h0);
        tick();
        check("cmds_pulse", 64'(cmds), 64'h0000000000000100);
        tick();
        check("cmds_cleared", 64'(cmds), 64'h0);

        // No partial field visible while in COMMIT; neighbours untouched
        send_frame(7, {8'hA5, 8'h02, 8'h00, 32'hDEADBEEF, 40'h0});
        check("freq2_in_commit", 64'(freq[2]), 64'h2A00);
        tick();
        check("freq2_written", 64'(freq[2]), 64'hDEADBEEF);
        check("freq1_untouched", 64'(freq[1]), 64'h0);
        check("freq5_untouched", 64'(freq[5]), 64'h12345678);

        // Out-of-range channel, then a clean frame
        send_raw(2, {8'hA5, 8'h09, 80'h0});
        check("badch_err", 64'(err), 64'h1);
        tick();
        check("badch_err_clear", 64'(err), 64'h0);
        send_frame(7, {8'hA5, 8'h01, 8'h00, 32'h00000007, 40'h0});
        tick();
        check("recover_freq1", 64'(freq[1]), 64'h7);

        // 0xA5 as channel byte is data, hence out of range
        send_raw(2, {8'hA5, 8'hA5, 80'h0});
        check("a5_chan_err", 64'(err), 64'h1);
        tick();

        // Envelope step just past the table is an unknown id
        send_raw(3, {8'hA5, 8'h01, 8'h14, 72'h0});
        check("badid_err", 64'(err), 64'h1);
        tick();
        check("badid_err_clear", 64'(err), 64'h0);

        // Gap timeout inside the payload
        send_raw(4, {8'hA5, 8'h00, 8'h00, 8'h12, 64'h0});
        repeat (TO - 1) tick();
        check("timeout_not_yet", 64'(err), 64'h0);
        tick();
        check("timeout_err", 64'(err), 64'h1);
        check("timeout_freq0", 64'(freq[0]), 64'hA5A5A5A5);
        tick();
        check("timeout_err_clear", 64'(err), 64'h0);
        send_frame(7, {8'hA5, 8'h00, 8'h00, 32'h00000100, 40'h0});
        tick();
        check("post_timeout_freq0", 64'(freq[0]), 64'h100);

`ifdef VOICE_CMD_CHECKSUM_EN
        send_raw(5, {8'hA5, 8'h00, 8'h03, 8'h01, 8'h05, 56'h0});
        check("chk_bad_err", 64'(err), 64'h1);
        tick();
        check("chk_bad_enable", 64'(enable[0]), 64'h0);
        send_raw(5, {8'hA5, 8'h00, 8'h03, 8'h01, 8'h02, 56'h0});
        check("chk_good_commit", 64'(rx_ready), 64'h0);
        tick();
        check("chk_good_enable", 64'(enable[0]), 64'h1);
        check("chk_good_err", 64'(err), 64'h0);
`endif

        // Reset mid-frame drops the frame without err
        send_raw(4, {8'hA5, 8'h03, 8'h00, 8'h11, 64'h0});
        rst = 1'b1;
        tick();
        check("midrst_err", 64'(err), 64'h0);
        check("midrst_ready", 64'(rx_ready), 64'h0);
        rst = 1'b0;
        tick();
        check("midrst_ready_back", 64'(rx_ready), 64'h1);
        check("midrst_freq2", 64'(freq[2]), 64'h0);
        send_frame(7, {8'hA5, 8'h03, 8'h00, 32'h00000055, 40'h0});
        tick();
        check("midrst_freq3", 64'(freq[3]), 64'h55);
        check("midrst_err_after", 64'(err), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
